// File: rtl/jtag_scan_master.sv
// JTAG scan initiator: turns one host command (TAP reset, IR/DR scan, idle clocks)
// into a tck/tms/tdi bit stream and returns the tdo bits captured during the shift.
module jtag_scan_master #(
  parameter int DW          = 64,
  parameter int HALF_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [$clog2(DW):0]  cmd_len,
  input  logic [DW-1:0]        cmd_data,
  output logic                 rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);

  localparam int LW = $clog2(DW) + 1;
  localparam int CW = (LW < 3) ? 3 : LW;
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_TMSRUN} state_e;

  state_e          state_q, state_d, next_state;
  logic [CW-1:0]   cnt_q, cnt_d, next_cnt, len_q, len_d, len_eff;
  logic [HW-1:0]   half_q, half_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic            tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic            rsp_valid_q, rsp_valid_d, last_bit;

  // TMS value of bit c of segment s; the header is 1,0,0 for DR and 1,1,0,0 for IR
  function automatic logic bit_tms(state_e s, logic [CW-1:0] c, logic [1:0] op,
                                   logic [CW-1:0] len);
    case (s)
      S_HDR:    bit_tms = (c == '0) || ((op == OP_IR) && (c == CW'(1)));
      S_SHIFT:  bit_tms = (c == len - CW'(1));
      S_TRL:    bit_tms = (c == '0);
      S_TMSRUN: bit_tms = (op == OP_RESET) && (c < CW'(5));
      default:  bit_tms = 1'b0;
    endcase
  endfunction

  function automatic logic bit_tdi(state_e s, logic [CW-1:0] c, logic [DW-1:0] d);
    logic [DW-1:0] sh;
    sh = d >> c;
    bit_tdi = (s == S_SHIFT) && sh[0];
  endfunction

  assign len_eff = (cmd_len == '0) ? CW'(1) :
                   (CW'(cmd_len) > CW'(DW)) ? CW'(DW) : CW'(cmd_len);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    next_state  = state_q;
    next_cnt    = cnt_q + CW'(1);

    case (state_q)
      S_HDR:    last_bit = (cnt_q == ((op_q == OP_IR) ? CW'(3) : CW'(2)));
      S_SHIFT:  last_bit = (cnt_q == len_q - CW'(1));
      S_TRL:    last_bit = (cnt_q == CW'(1));
      S_TMSRUN: last_bit = (cnt_q == ((op_q == OP_RESET) ? CW'(5) : len_q - CW'(1)));
      default:  last_bit = 1'b0;
    endcase

    if (last_bit) begin
      next_cnt = '0;
      case (state_q)
        S_HDR:   next_state = S_SHIFT;
        S_SHIFT: next_state = S_TRL;
        default: next_state = S_IDLE;
      endcase
    end

    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        op_d    = cmd_op;
        len_d   = len_eff;
        data_d  = cmd_data;
        cap_d   = '0;
        cnt_d   = '0;
        half_d  = '0;
        tck_d   = 1'b0;
        state_d = ((cmd_op == OP_RESET) || (cmd_op == OP_IDLE)) ? S_TMSRUN : S_HDR;
        tms_d   = bit_tms(state_d, '0, cmd_op, len_eff);
        tdi_d   = 1'b0;
      end
    end else if (half_q != HALF_LAST) begin
      half_d = half_q + HW'(1);
    end else begin
      half_d = '0;
      if (!tck_q) begin
        // tdo was driven on the previous tck fall, so it is stable at this rise
        tck_d = 1'b1;
        if (state_q == S_SHIFT) cap_d = cap_q | (DW'(tdo) << cnt_q);
      end else begin
        tck_d   = 1'b0;
        state_d = next_state;
        cnt_d   = next_cnt;
        if (next_state == S_IDLE) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
          tms_d       = 1'b0;
          tdi_d       = 1'b0;
        end else begin
          tms_d = bit_tms(next_state, next_cnt, op_q, len_q);
          tdi_d = bit_tdi(next_state, next_cnt, data_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      op_q        <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master driving a small behavioural TAP (IDCODE + BYPASS).
module tb_jtag_scan_master;

  localparam int DW = 64;
  localparam int H  = 2;
  localparam logic [3:0]  IR_IDCODE  = 4'b0010;
  localparam logic [3:0]  IR_BYPASS  = 4'b1111;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_5677;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [1:0]    cmd_op;
  logic [6:0]    cmd_len;
  logic [DW-1:0] cmd_data, rsp_data;

  int checks = 0;
  int failures = 0;
  int rise_cnt = 0;
  int rsp_pulses = 0;
  int viol = 0;
  logic [63:0] tms_rec = '0;

  always #5 clk = ~clk;

  jtag_scan_master #(.DW(DW), .HALF_PERIOD(H)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // Behavioural TAP controller
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;
  tap_e        tap_st;
  logic [3:0]  ir_q, ir_sr;
  logic [31:0] id_sr;
  logic        byp;
  wire         tap_rst_n = ~rst;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PDR;
      PDR:     return m ? EX2DR : PDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PIR;
      PIR:     return m ? EX2IR : PIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge tap_rst_n) begin
    if (!tap_rst_n) begin
      tap_st <= TLR; ir_q <= IR_IDCODE; ir_sr <= '0; id_sr <= '0; byp <= 1'b0;
    end else begin
      case (tap_st)
        TLR:   ir_q  <= IR_IDCODE;
        CAPIR: ir_sr <= 4'b0101;
        SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
        UPIR:  ir_q  <= ir_sr;
        CAPDR: begin id_sr <= IDCODE_VAL; byp <= 1'b0; end
        SHDR:  begin id_sr <= {tdi, id_sr[31:1]}; byp <= tdi; end
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck or negedge tap_rst_n) begin
    if (!tap_rst_n) tdo <= 1'b0;
    else if (tap_st == SHIR) tdo <= ir_sr[0];
    else if (tap_st == SHDR) tdo <= (ir_q == IR_IDCODE) ? id_sr[0] : byp;
    else tdo <= 1'b0;
  end

  // Records the tms stream seen by the TAP, oldest bit ends up highest
  always @(posedge tck) begin
    tms_rec = {tms_rec[62:0], tms};
    rise_cnt++;
  end

  always @(posedge clk) if (rsp_valid === 1'b1) rsp_pulses++;

  // tms/tdi must only move when tck falls, and every tck high phase lasts H clocks
  logic p_tck = 1'b0, p_tms = 1'b0, p_tdi = 1'b0, r;
  int   hi = 0;
  always @(posedge clk) begin
    r = rst;
    #1;
    if (tck && (tms != p_tms || tdi != p_tdi)) viol++;
    if (r) hi = 0;
    else if (tck) hi++;
    else begin
      if (p_tck && hi != H) viol++;
      hi = 0;
    end
    p_tck = tck; p_tms = tms; p_tdi = tdi;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command and waits for its response; cyc is the cycle index of
  // rsp_valid counted from the accept cycle k (-1 on timeout)
  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] len,
                               input logic [63:0] data, output logic [63:0] rsp,
                               output int cyc, output int periods);
    int w, r0;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    r0 = rise_cnt;
    #1 cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    if (!rsp_valid) cyc = -1;
    rsp = rsp_data;
    periods = rise_cnt - r0;
  endtask

  logic [63:0] rsp;
  int cyc, per, n, p0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tck", 64'(tck), 64'd0);
    checkOutput("rst_tms", 64'(tms), 64'd1);
    checkOutput("rst_tdi", 64'(tdi), 64'd0);
    checkOutput("rst_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rspv", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rspd", rsp_data, 64'd0);
    rst = 1'b0;

    applyStimulus(2'b00, 7'd0, 64'd0, rsp, cyc, per);
    checkOutput("op00_cyc", 64'(cyc), 64'd25);
    checkOutput("op00_periods", 64'(per), 64'd6);
    checkOutput("op00_tms", 64'(tms_rec[5:0]), 64'b111110);
    checkOutput("op00_tap", 64'(tap_st), 64'(RTI));
    checkOutput("op00_rsp", rsp, 64'd0);
    checkOutput("idle_tms", 64'(tms), 64'd0);

    applyStimulus(2'b01, 7'd4, 64'(IR_IDCODE), rsp, cyc, per);
    checkOutput("ir_id_cyc", 64'(cyc), 64'd41);
    checkOutput("ir_id_rsp", rsp, 64'h5);
    checkOutput("ir_id_value", 64'(ir_q), 64'(IR_IDCODE));

    applyStimulus(2'b10, 7'd32, 64'd0, rsp, cyc, per);
    checkOutput("dr_idcode", rsp, 64'h0000_0000_1234_5677);
    checkOutput("dr_id_periods", 64'(per), 64'd37);

    applyStimulus(2'b11, 7'd5, 64'hFF, rsp, cyc, per);
    checkOutput("op11_rsp", rsp, 64'd0);
    checkOutput("op11_periods", 64'(per), 64'd5);

    applyStimulus(2'b01, 7'd4, 64'(IR_BYPASS), rsp, cyc, per);
    checkOutput("ir_byp_rsp", rsp, 64'h5);

    applyStimulus(2'b10, 7'd8, 64'hA5, rsp, cyc, per);
    checkOutput("byp_a5_rsp", rsp, 64'h4A);
    checkOutput("byp_a5_periods", 64'(per), 64'd13);

    applyStimulus(2'b10, 7'd0, 64'h1, rsp, cyc, per);
    checkOutput("len0_rsp", rsp, 64'd0);
    checkOutput("len0_periods", 64'(per), 64'd6);
    checkOutput("len0_cyc", 64'(cyc), 64'd25);
    checkOutput("len0_tms", 64'(tms_rec[5:0]), 64'b100110);

    applyStimulus(2'b10, 7'd100, {64{1'b1}}, rsp, cyc, per);
    checkOutput("len100_rsp", rsp, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("len100_periods", 64'(per), 64'd69);
    checkOutput("len100_cyc", 64'(cyc), 64'd277);

    // Back-to-back: cmd_valid held high across the first response
    @(negedge clk);
    cmd_op = 2'b11; cmd_len = 7'd3; cmd_data = '0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = 2'b00;
    n = 1;
    while (!rsp_valid && n < 500) begin @(posedge clk); #1; n++; end
    checkOutput("b2b_first_cyc", 64'(n), 64'd13);
    checkOutput("b2b_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    n = 1;
    while (!rsp_valid && n < 500) begin @(posedge clk); #1; n++; end
    checkOutput("b2b_second_cyc", 64'(n), 64'd25);
    checkOutput("b2b_tap", 64'(tap_st), 64'(RTI));

    // Reset in the middle of a 16-bit DR shift
    @(negedge clk);
    cmd_op = 2'b10; cmd_len = 7'd16; cmd_data = 64'hFFFF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_busy", 64'(busy), 64'd1);
    p0 = rsp_pulses;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_tck", 64'(tck), 64'd0);
    checkOutput("abort_tms", 64'(tms), 64'd1);
    checkOutput("abort_ready", 64'(cmd_ready), 64'd1);
    checkOutput("abort_rspv", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    checkOutput("abort_no_rsp", 64'(rsp_pulses - p0), 64'd0);

    applyStimulus(2'b00, 7'd0, 64'd0, rsp, cyc, per);
    checkOutput("post_op00_tap", 64'(tap_st), 64'(RTI));
    applyStimulus(2'b01, 7'd4, 64'(IR_IDCODE), rsp, cyc, per);
    applyStimulus(2'b10, 7'd32, 64'd0, rsp, cyc, per);
    checkOutput("post_idcode", rsp, 64'h0000_0000_1234_5677);

    repeat (4) @(posedge clk);
    checkOutput("tck_phase_rules", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
